// File: rtl/muldiv_seq_pkg.sv
// Shared types and opcode constants for the RV32M multiply/divide sequencer.
// OPERANDS_WIDTH supplies the default operand width when the build does not set it.
// The optional macro MULDIV_FAST_MUL_EN is consumed by muldiv_seq.
`ifndef OPERANDS_WIDTH
`define OPERANDS_WIDTH 32
`endif

package muldiv_seq_pkg;

  localparam int MULDIV_OP_WIDTH = 3;

  // funct3 encodings of the M extension
  localparam logic [MULDIV_OP_WIDTH-1:0] MULDIV_OP_MUL    = 3'd0;
  localparam logic [MULDIV_OP_WIDTH-1:0] MULDIV_OP_MULH   = 3'd1;
  localparam logic [MULDIV_OP_WIDTH-1:0] MULDIV_OP_MULHSU = 3'd2;
  localparam logic [MULDIV_OP_WIDTH-1:0] MULDIV_OP_MULHU  = 3'd3;
  localparam logic [MULDIV_OP_WIDTH-1:0] MULDIV_OP_DIV    = 3'd4;
  localparam logic [MULDIV_OP_WIDTH-1:0] MULDIV_OP_DIVU   = 3'd5;
  localparam logic [MULDIV_OP_WIDTH-1:0] MULDIV_OP_REM    = 3'd6;
  localparam logic [MULDIV_OP_WIDTH-1:0] MULDIV_OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // rs1 is treated as two's complement
  function automatic logic op_a_signed(input logic [MULDIV_OP_WIDTH-1:0] op);
    return (op == MULDIV_OP_MULH) || (op == MULDIV_OP_MULHSU) ||
           (op == MULDIV_OP_DIV)  || (op == MULDIV_OP_REM);
  endfunction

  // rs2 is treated as two's complement
  function automatic logic op_b_signed(input logic [MULDIV_OP_WIDTH-1:0] op);
    return (op == MULDIV_OP_MULH) || (op == MULDIV_OP_DIV) || (op == MULDIV_OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One iteration of the unsigned multiply/divide datapath on the {acc,q} pair.
// Multiply: shift-add, LSB of q selects whether the multiplicand is added; the
//   pair shifts right so {acc,q} holds the 2*XLEN product after XLEN steps.
// Divide: restoring step, the pair shifts left and the divisor is subtracted
//   when it fits; q collects quotient bits, acc ends as the remainder.
// Purely combinational: the caller owns the registers.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            i_div,
  input  logic [XLEN-1:0] i_acc,
  input  logic [XLEN-1:0] i_q,
  input  logic [XLEN-1:0] i_opnd,
  output logic [XLEN-1:0] o_acc,
  output logic [XLEN-1:0] o_q
);

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_diff;
  logic            w_fits;

  // next {acc,q} for the selected mode
  always_comb begin
    w_sum   = {1'b0, i_acc};
    w_shift = {i_acc, i_q[XLEN-1]};
    w_fits  = (w_shift >= {1'b0, i_opnd});
    // the partial remainder stays below the divisor, so XLEN bits suffice
    w_diff  = w_shift[XLEN-1:0] - i_opnd;
    o_acc   = i_acc;
    o_q     = i_q;
    if (i_div) begin
      if (w_fits) begin
        o_acc = w_diff;
        o_q   = {i_q[XLEN-2:0], 1'b1};
      end else begin
        o_acc = w_shift[XLEN-1:0];
        o_q   = {i_q[XLEN-2:0], 1'b0};
      end
    end else begin
      if (i_q[0]) begin
        w_sum = {1'b0, i_acc} + {1'b0, i_opnd};
      end
      o_acc = w_sum[XLEN:1];
      o_q   = {w_sum[0], i_q[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer for the execute stage.
// Operands are captured as magnitudes, iterated one bit per cycle through
// muldiv_iter, and sign-corrected into the result register when DONE retires.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies complete through a
// single-cycle combinational product instead of iterating.
//
// state   | meaning
// IDLE    | waiting for start; operands captured on an accepted start
// CALC    | one datapath step per cycle, XLEN cycles
// DONE    | result fix-up; leaving DONE writes result and pulses done
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN  = `OPERANDS_WIDTH,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [MULDIV_OP_WIDTH-1:0] op,
  input  logic [XLEN-1:0]            A,
  input  logic [XLEN-1:0]            B,
  input  logic                       flush,
  output logic                       busy,
  output logic                       done,
  output logic [XLEN-1:0]            result
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t r_state;
  state_t w_state_nxt;

  logic [MULDIV_OP_WIDTH-1:0] r_op;
  logic [XLEN-1:0]            r_acc;
  logic [XLEN-1:0]            r_q;
  logic [XLEN-1:0]            r_opnd;
  logic [XLEN-1:0]            r_spec_res;
  logic [XLEN-1:0]            r_result;
  logic [CNT_W-1:0]           r_cnt;
  logic                       r_neg_q;
  logic                       r_neg_r;
  logic                       r_special;
  logic                       r_done;

  logic                       w_load;
  logic                       w_step;
  logic                       w_finish;
  logic                       w_is_div;
  logic                       w_sa;
  logic                       w_sb;
  logic                       w_div0;
  logic                       w_ovf;
  logic                       w_special;
  logic                       w_fast;
  logic [XLEN-1:0]            w_mag_a;
  logic [XLEN-1:0]            w_mag_b;
  logic [XLEN-1:0]            w_spec_res;
  logic [2*XLEN-1:0]          w_fast_prod;
  logic [XLEN-1:0]            w_acc_nxt;
  logic [XLEN-1:0]            w_q_nxt;
  logic [2*XLEN-1:0]          w_prod;
  logic [2*XLEN-1:0]          w_prod_fix;
  logic [XLEN-1:0]            w_quo_fix;
  logic [XLEN-1:0]            w_rem_fix;
  logic [XLEN-1:0]            w_final;

  // operand decode, magnitudes and special-case detection at capture time
  always_comb begin
    w_is_div   = op[2];
    w_sa       = A[XLEN-1] & op_a_signed(op);
    w_sb       = B[XLEN-1] & op_b_signed(op);
    w_mag_a    = w_sa ? -A : A;
    w_mag_b    = w_sb ? -B : B;
    w_div0     = w_is_div && (B == '0);
    w_ovf      = ((op == MULDIV_OP_DIV) || (op == MULDIV_OP_REM)) &&
                 (A == MIN_NEG) && (B == '1);
    w_special  = w_div0 | w_ovf;
    // REM* keeps the dividend on /0 and yields 0 on overflow; DIV* gives -1 or MIN_NEG
    if (op[1]) begin
      w_spec_res = w_div0 ? A : '0;
    end else begin
      w_spec_res = w_div0 ? '1 : A;
    end
`ifdef MULDIV_FAST_MUL_EN
    w_fast      = ~w_is_div;
    w_fast_prod = {{XLEN{1'b0}}, w_mag_a} * {{XLEN{1'b0}}, w_mag_b};
`else
    w_fast      = 1'b0;
    w_fast_prod = '0;
`endif
  end

  muldiv_iter #(
    .XLEN (XLEN)
  ) u_iter (
    .i_div  (r_op[2]),
    .i_acc  (r_acc),
    .i_q    (r_q),
    .i_opnd (r_opnd),
    .o_acc  (w_acc_nxt),
    .o_q    (w_q_nxt)
  );

  // sign fix-up and result select applied as DONE retires
  always_comb begin
    w_prod     = {r_acc, r_q};
    w_prod_fix = r_neg_q ? -w_prod : w_prod;
    w_quo_fix  = r_neg_q ? -r_q : r_q;
    w_rem_fix  = r_neg_r ? -r_acc : r_acc;
    if (r_special) begin
      w_final = r_spec_res;
    end else if (r_op[2]) begin
      w_final = r_op[1] ? w_rem_fix : w_quo_fix;
    end else if (r_op == MULDIV_OP_MUL) begin
      w_final = w_prod_fix[XLEN-1:0];
    end else begin
      w_final = w_prod_fix[2*XLEN-1:XLEN];
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next state and datapath strobes; flush overrides everything but reset
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = (w_special || w_fast) ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        w_step = 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_finish    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (flush) begin
      w_state_nxt = ST_IDLE;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_finish    = 1'b0;
    end
  end

  // operand capture, iteration, counter and result/done registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op       <= '0;
      r_acc      <= '0;
      r_q        <= '0;
      r_opnd     <= '0;
      r_spec_res <= '0;
      r_result   <= '0;
      r_cnt      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_special  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_load) begin
        r_op       <= op;
        r_neg_q    <= w_sa ^ w_sb;
        r_neg_r    <= w_sa;
        r_special  <= w_special;
        r_spec_res <= w_spec_res;
        r_cnt      <= CNT_W'(XLEN - 1);
        r_opnd     <= w_is_div ? w_mag_b : w_mag_a;
        if (w_fast) begin
          {r_acc, r_q} <= w_fast_prod;
        end else begin
          r_acc <= '0;
          r_q   <= w_is_div ? w_mag_a : w_mag_b;
        end
      end else if (w_step) begin
        r_acc <= w_acc_nxt;
        r_q   <= w_q_nxt;
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_finish) begin
        r_result <= w_final;
      end
    end
  end

  assign busy   = (r_state == ST_CALC) || (r_state == ST_DONE);
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with hand-computed results and latencies.
// Latency is counted in rising edges from the edge that accepts start to the
// edge after which done is seen high.
`ifndef OPERANDS_WIDTH
`define OPERANDS_WIDTH 32
`endif

module tb_muldiv_seq;

  localparam int SLOW_LAT = 33;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = SLOW_LAT;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_seq #(
    .XLEN (`OPERANDS_WIDTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .A      (A),
    .B      (B),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // issue one op, wait (bounded) for done, check latency, result and one-cycle pulse
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    logic seen;
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) seen = 1'b1;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, result, exp_res);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int ndone;
    int lat;
    logic [31:0] res_at_done;

    rst = 1'b1; start = 1'b0; op = 3'd0; A = '0; B = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_res", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // multiplies
    do_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    do_op("mul_7x6",   3'd0, 32'd7,         32'd6,         32'd42,         MUL_LAT);
    do_op("mul_neg",   3'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, MUL_LAT);
    do_op("mulh_neg",  3'd1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, MUL_LAT);
    do_op("mulh_min",  3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
    do_op("mulhsu",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
    do_op("mulhu_big", 3'd3, 32'h8000_0000, 32'd6,         32'd3,          MUL_LAT);

    // divides
    do_op("div_m7_2",  3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, SLOW_LAT);
    do_op("rem_m7_2",  3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, SLOW_LAT);
    do_op("divu_100",  3'd5, 32'd100,       32'd7,         32'd14,         SLOW_LAT);
    do_op("remu_100",  3'd7, 32'd100,       32'd7,         32'd2,          SLOW_LAT);
    do_op("div_7_m2",  3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, SLOW_LAT);
    do_op("rem_7_m2",  3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,          SLOW_LAT);
    do_op("divu_big",  3'd5, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, SLOW_LAT);

    // special cases finish one edge after acceptance
    do_op("div_by0",   3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    do_op("rem_by0",   3'd6, 32'd5,         32'd0,         32'd5,          1);
    do_op("divu_by0",  3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    do_op("remu_by0",  3'd7, 32'd9,         32'd0,         32'd9,          1);
    do_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,          1);

    // start re-pulsed mid-CALC with another dividend is ignored
    @(negedge clk);
    start = 1'b1; op = 3'd5; A = 32'd100; B = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; A = 32'd50;
    @(posedge clk);
    #1;
    start = 1'b0; A = 32'd100;
    ndone = 0; lat = 0; res_at_done = '0;
    for (int k = 6; k <= 45; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        lat = k;
        res_at_done = result;
      end
    end
    chk("restart_ndone", ndone, 1);
    chk("restart_lat", lat, SLOW_LAT);
    chk("restart_res", res_at_done, 32'd14);

    // flush at CALC cycle 10 aborts without done and keeps the old result
    @(negedge clk);
    start = 1'b1; op = 3'd5; A = 32'd99; B = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_done", {31'd0, done}, 32'd0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("flush_nodone", ndone, 0);
    chk("flush_res", result, 32'd14);
    do_op("post_flush", 3'd5, 32'd200, 32'd7, 32'd28, SLOW_LAT);

    // flush together with start in IDLE drops the start
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd5; A = 32'd10; B = 32'd2;
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_idle_busy", {31'd0, busy}, 32'd0);

    // reset mid-CALC clears everything
    @(negedge clk);
    start = 1'b1; op = 3'd3; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_res", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op("post_rst", 3'd5, 32'd9, 32'd3, 32'd3, SLOW_LAT);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
